knn_local_sp_arbiter: RTL and testbench

Shares one single-port local memory (256-bit x 2048, one address/ce/we port, registered read data) between two requesters: a write stream that fills the partial-KNN search buffer from the loader, and a read stream that fetches vectors for the distance pipeline. The block does round-robin arbitration and tracks the memory read latency with a valid shift pipeline. Read responses land in an internal response FIFO so the consumer can apply backpressure without losing data. It sits between the loader/compute stages and the memory instance.

---
 rtl/knn_local_sp_arbiter.sv | 147 ++++++++++++++
 tb/tb_knn_local_sp_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/knn_local_sp_arbiter.sv
// Shares one single-port local memory between the partial-KNN buffer write
// stream (loader) and the vector read stream (distance pipeline). Grants are
// round-robin. Outstanding reads are tracked through a MEM_LAT-deep valid
// pipeline. Read data is collected in a credit-protected response FIFO.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data  write request channel
//   rd_valid/rd_ready/rd_addr          read request channel
//   rsp_valid/rsp_ready/rsp_data       read response channel (request order)
//   mem_address0/ce0/we0/d0/q0         single-port memory interface
module knn_local_sp_arbiter #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] mem_address0,
  output logic              mem_ce0,
  output logic              mem_we0,
  output logic [DATA_W-1:0] mem_d0,
  input  logic [DATA_W-1:0] mem_q0
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(RSP_DEPTH + MEM_LAT + 1);

  logic               last_grant_q, last_grant_d;  // 0 = write, 1 = read
  logic [MEM_LAT-1:0] vpipe_q, vpipe_d;
  logic [DATA_W-1:0]  fifo_q [RSP_DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [OCC_W-1:0]   occupancy;
  logic               rd_elig;
  logic               grant_wr;
  logic               grant_rd;
  logic               push;
  logic               pop;

  // Entries already in the FIFO plus reads still travelling through memory;
  // a read is only issued if a FIFO slot is guaranteed for its data.
  always_comb begin
    occupancy = OCC_W'(count_q);
    for (int i = 0; i < int'(MEM_LAT); i++) begin
      occupancy = occupancy + OCC_W'(vpipe_q[i]);
    end
  end

  assign rd_elig = rd_valid && (occupancy < OCC_W'(RSP_DEPTH));

  // Round-robin arbitration: on contention the side not granted last wins.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (!reset) begin
      if (wr_valid && rd_elig) begin
        grant_wr = last_grant_q;
        grant_rd = ~last_grant_q;
      end else begin
        grant_wr = wr_valid;
        grant_rd = rd_elig;
      end
    end
  end

  assign last_grant_d = grant_rd ? 1'b1 : (grant_wr ? 1'b0 : last_grant_q);

  // Memory port driven straight from the grant; address/data are don't-care when idle.
  assign wr_ready     = grant_wr;
  assign rd_ready     = grant_rd;
  assign mem_ce0      = grant_wr | grant_rd;
  assign mem_we0      = grant_wr;
  assign mem_address0 = grant_wr ? wr_addr : rd_addr;
  assign mem_d0       = wr_data;

  // Read-latency tracker: stage 0 marks a read issued this cycle.
  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = grant_rd;
    for (int i = 1; i < int'(MEM_LAT); i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
  end

  assign push      = vpipe_q[MEM_LAT-1];
  assign rsp_valid = !reset && (count_q != '0);
  assign rsp_data  = fifo_q[rptr_q];
  assign pop       = rsp_valid && rsp_ready;

  // FIFO pointer/count update with explicit modulo-RSP_DEPTH wrap.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = (wptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state; reset drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      vpipe_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      assert (!(push && !pop && (count_q == CNT_W'(RSP_DEPTH))));
      last_grant_q <= last_grant_d;
      vpipe_q      <= vpipe_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage needs no reset; count_q qualifies every entry.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_q[wptr_q] <= mem_q0;
    end
  end

endmodule

// File: tb/tb_knn_local_sp_arbiter.sv
// Directed bench for knn_local_sp_arbiter with a 2-cycle memory model and a
// response scoreboard (expected read data queued when a read is accepted).
module tb_knn_local_sp_arbiter;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned ADDR_W = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] mem_address0;
  logic              mem_ce0;
  logic              mem_we0;
  logic [DATA_W-1:0] mem_d0;
  logic [DATA_W-1:0] mem_q0;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] ref_mem [2048];
  logic [DATA_W-1:0] mem_arr [2048];
  logic [DATA_W-1:0] rd_s1;

  always #5 clk = ~clk;

  knn_local_sp_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(2), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
    .mem_d0(mem_d0), .mem_q0(mem_q0)
  );

  // Single-port memory, two-cycle registered read.
  always @(posedge clk) begin
    if (mem_ce0 && mem_we0) mem_arr[mem_address0] <= mem_d0;
    if (mem_ce0 && !mem_we0) rd_s1 <= mem_arr[mem_address0];
    mem_q0 <= rd_s1;
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, DATA_W'(obs), DATA_W'(exp));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: reference memory follows accepted writes, accepted reads queue data.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (wr_valid && wr_ready) ref_mem[wr_addr] = wr_data;
      if (rd_valid && rd_ready) sb.push_back(ref_mem[rd_addr]);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk1("rsp_unexpected", 1'b1, 1'b0);
        else chk("rsp_data", rsp_data, sb.pop_front());
      end
    end
  end

  initial begin
    logic seen;
    reset = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    next_cycle();
    @(negedge clk);
    chk1("rst_wr_ready", wr_ready, 1'b0);
    chk1("rst_rd_ready", rd_ready, 1'b0);
    chk1("rst_ce", mem_ce0, 1'b0);
    chk1("rst_we", mem_we0, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    next_cycle();
    reset = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;

    // Write-only fill 0..3 with A0..A3.
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(32'hA0 + i);
      @(negedge clk);
      chk1("w_ready", wr_ready, 1'b1);
      chk1("w_we", mem_we0, 1'b1);
      chk1("w_ce", mem_ce0, 1'b1);
      chk("w_d0", mem_d0, DATA_W'(32'hA0 + i));
      chk1("w_rsp_valid", rsp_valid, 1'b0);
      next_cycle();
    end
    wr_valid = 1'b0;

    // Read-only 0..3: first response visible two edges after the first accept edge.
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_valid = 1'b1; rd_addr = ADDR_W'(i);
      @(negedge clk);
      chk1("r_ready", rd_ready, 1'b1);
      chk1("r_we", mem_we0, 1'b0);
      chk1("r_ce", mem_ce0, 1'b1);
      chk1("r_rsp_valid", rsp_valid, i >= 3);
      next_cycle();
    end
    rd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("r_drain_valid", rsp_valid, i < 3);
      next_cycle();
    end
    chk("r_sb_empty", DATA_W'(sb.size()), '0);

    // Contention: alternate grants starting with write.
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_addr = ADDR_W'(16 + i); wr_data = DATA_W'(32'hB0 + i);
      rd_valid = 1'b1; rd_addr = ADDR_W'(i % 4);
      @(negedge clk);
      chk1("rr_wr_ready", wr_ready, (i % 2) == 0);
      chk1("rr_rd_ready", rd_ready, (i % 2) == 1);
      chk1("rr_we", mem_we0, (i % 2) == 0);
      chk("rr_addr", DATA_W'(mem_address0), ((i % 2) == 0) ? DATA_W'(16 + i) : DATA_W'(i % 4));
      next_cycle();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    for (int i = 0; i < 5; i++) next_cycle();
    @(negedge clk);
    chk1("rr_drained", rsp_valid, 1'b0);
    next_cycle();

    // Backpressure: only RSP_DEPTH reads accepted, writes still pass.
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_valid = 1'b1; rd_addr = ADDR_W'(i % 4);
      wr_valid = (i >= 5); wr_addr = ADDR_W'(40 + i); wr_data = DATA_W'(32'hC0 + i);
      @(negedge clk);
      chk1("bp_rd_ready", rd_ready, i < 4);
      chk1("bp_wr_ready", wr_ready, i >= 5);
      next_cycle();
    end
    wr_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      rd_valid = 1'b1; rd_addr = ADDR_W'(j % 4);
      @(negedge clk);
      chk1("bp_resume_rd_ready", rd_ready, j >= 1);
      chk1("bp_resume_rsp_valid", rsp_valid, 1'b1);
      next_cycle();
    end
    rd_valid = 1'b0;
    for (int i = 0; i < 6; i++) next_cycle();
    chk("bp_sb_empty", DATA_W'(sb.size()), '0);

    // Fill 64..75, then push/pop at count 2 repeatedly across pointer wrap.
    for (int k = 0; k < 12; k++) begin
      wr_valid = 1'b1; wr_addr = ADDR_W'(64 + k); wr_data = DATA_W'(32'hD00 + k);
      next_cycle();
    end
    wr_valid = 1'b0;
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < 8; a++) begin
        rd_valid = (a < 3); rd_addr = ADDR_W'(64 + it * 3 + a);
        rsp_ready = (a >= 4);
        @(negedge clk);
        if (a < 3) chk1("pp_rd_ready", rd_ready, 1'b1);
        else chk1("pp_rsp_valid", rsp_valid, a != 7);
        next_cycle();
      end
    end
    rd_valid = 1'b0;

    // Reset with two reads in flight: stale data must never surface.
    rsp_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      rd_valid = 1'b1; rd_addr = ADDR_W'(i);
      @(negedge clk);
      chk1("rst2_rd_ready", rd_ready, 1'b1);
      next_cycle();
    end
    rd_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk1("rst2_rsp_valid_in_reset", rsp_valid, 1'b0);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("rst2_no_stale", rsp_valid, 1'b0);
      next_cycle();
    end
    rd_valid = 1'b1; rd_addr = ADDR_W'(3);
    next_cycle();
    rd_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      next_cycle();
    end
    chk1("rst2_rsp_seen", seen, 1'b1);
    for (int i = 0; i < 3; i++) next_cycle();
    chk("final_sb_empty", DATA_W'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
